// File: rtl/dacx_spi_slave_model_if.sv
// SPI pin bundle and live DAC output bus for the DACx05xx slave model.
// Master drives SCLK/CS_N/SDI; the slave drives SDO and the DAC code outputs.
interface dacx_spi_slave_model_if #(
  parameter int unsigned NUM_CH = 4
);
  logic                     DAC_SCLK;
  logic                     DAC_CS_N;
  logic                     DAC_SDI;
  logic                     DAC_SDO;
  logic [NUM_CH*16-1:0]     DAC_CODE;
  logic [NUM_CH-1:0]        DAC_UPDATE;
  logic                     FRAME_DONE;

  modport master (
    output DAC_SCLK, DAC_CS_N, DAC_SDI,
    input  DAC_SDO, DAC_CODE, DAC_UPDATE, FRAME_DONE
  );

  modport slave (
    input  DAC_SCLK, DAC_CS_N, DAC_SDI,
    output DAC_SDO, DAC_CODE, DAC_UPDATE, FRAME_DONE
  );
endinterface

// File: rtl/dacx_spi_slave_model.sv
// Oversampled SPI slave model of a DACx05xx-family DAC with NUM_CH channels and sync/LDAC modes.
// Defining DACX_FRAME_ERR_EN adds a sticky frame-error flag in STATUS[1], cleared by reading it.
module dacx_spi_slave_model #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DAC_BITS  = 16,
  parameter logic [15:0] DEVICE_ID = 16'hABCD,
  parameter logic [15:0] GAIN_RST  = 16'h0001
) (
  input logic                   SYS_CLK,
  input logic                   SYS_RST_N,
  dacx_spi_slave_model_if.slave bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StShift  = 2'd1;
  localparam logic [1:0] StCommit = 2'd2;

  localparam logic [3:0] AddrDevId   = 4'h1;
  localparam logic [3:0] AddrSync    = 4'h2;
  localparam logic [3:0] AddrConfig  = 4'h3;
  localparam logic [3:0] AddrGain    = 4'h4;
  localparam logic [3:0] AddrTrigger = 4'h5;
  localparam logic [3:0] AddrBrdcast = 4'h6;
  localparam logic [3:0] AddrStatus  = 4'h7;

  // Codes are left-justified; unimplemented LSBs always read back as 0.
  localparam logic [15:0] CodeMask = 16'hFFFF << (16 - DAC_BITS);

  // Input synchronisers plus one extra stage for edge detection
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic cs_s1_q, cs_s2_q, cs_s3_q;
  logic sdi_s1_q, sdi_s2_q;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic [1:0]                   state_q, state_d;
  logic [4:0]                   bit_cnt_q, bit_cnt_d;
  logic [23:0]                  shift_in_q, shift_in_d;
  logic [23:0]                  shift_out_q, shift_out_d;
  logic [NUM_CH-1:0][15:0]      buf_q, buf_d;
  logic [NUM_CH-1:0][15:0]      code_q, code_d;
  logic [NUM_CH-1:0]            update_q, update_d;
  logic [15:0]                  sync_q, sync_d;
  logic [15:0]                  config_q, config_d;
  logic [15:0]                  gain_q, gain_d;
  logic [15:0]                  trigger_q, trigger_d;
  logic [15:0]                  brdcast_q, brdcast_d;
`ifdef DACX_FRAME_ERR_EN
  logic                         frame_err_q, frame_err_d;
`endif

  logic        frame_rd;
  logic [3:0]  frame_addr;
  logic [15:0] frame_data;
  logic        frame_ok;
  logic [15:0] rd_data;
  logic        soft_rst;
  logic        unused_bits;

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
  assign cs_fall   = ~cs_s2_q & cs_s3_q;
  assign cs_rise   = cs_s2_q & ~cs_s3_q;

  assign frame_rd    = shift_in_q[23];
  assign frame_addr  = shift_in_q[19:16];
  assign frame_data  = shift_in_q[15:0];
  assign frame_ok    = (bit_cnt_q == 5'd24);
  assign unused_bits = ^shift_in_q[22:20];

  assign bus.DAC_SDO    = shift_out_q[23];
  assign bus.DAC_CODE   = code_q;
  assign bus.DAC_UPDATE = update_q;
  assign bus.FRAME_DONE = (state_q == StCommit) && frame_ok;

  always_comb begin
    rd_data = 16'h0000;
    case (frame_addr)
      AddrDevId:   rd_data = DEVICE_ID;
      AddrSync:    rd_data = sync_q;
      AddrConfig:  rd_data = config_q;
      AddrGain:    rd_data = gain_q;
      AddrTrigger: rd_data = trigger_q;
      AddrBrdcast: rd_data = brdcast_q;
`ifdef DACX_FRAME_ERR_EN
      AddrStatus:  rd_data = {14'h0000, frame_err_q, 1'b0};
`else
      AddrStatus:  rd_data = 16'h0000;
`endif
      default: begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (frame_addr == 4'(8 + n)) rd_data = buf_q[n];
        end
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    buf_d       = buf_q;
    code_d      = code_q;
    update_d    = '0;
    sync_d      = sync_q;
    config_d    = config_q;
    gain_d      = gain_q;
    trigger_d   = trigger_q;
    brdcast_d   = brdcast_q;
    soft_rst    = 1'b0;
`ifdef DACX_FRAME_ERR_EN
    frame_err_d = frame_err_q;
`endif

    case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d    = StShift;
          bit_cnt_d  = 5'd0;
          shift_in_d = 24'h000000;
        end
      end
      StShift: begin
        // A CS_N rise seen in the same cycle as an SCLK edge ends the frame first.
        if (cs_rise) begin
          state_d = StCommit;
        end else begin
          if (sclk_rise) begin
            shift_in_d = {shift_in_q[22:0], sdi_s2_q};
            if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
          end
          if (sclk_fall) shift_out_d = {shift_out_q[22:0], 1'b0};
        end
      end
      StCommit: begin
        state_d = StIdle;
        if (!frame_ok) begin
          shift_out_d = 24'h000000;
`ifdef DACX_FRAME_ERR_EN
          frame_err_d = 1'b1;
`endif
        end else if (frame_rd) begin
          shift_out_d = {4'h8, frame_addr, rd_data};
`ifdef DACX_FRAME_ERR_EN
          if (frame_addr == AddrStatus) frame_err_d = 1'b0;
`endif
        end else begin
          case (frame_addr)
            AddrSync:   sync_d   = frame_data;
            AddrConfig: config_d = frame_data;
            AddrGain:   gain_d   = frame_data;
            AddrTrigger: begin
              trigger_d = frame_data;
              if (frame_data[3:0] == 4'b1010) begin
                soft_rst = 1'b1;
              end else if (frame_data[4]) begin
                for (int n = 0; n < NUM_CH; n++) begin
                  if (sync_q[n]) begin
                    code_d[n]   = buf_q[n];
                    update_d[n] = 1'b1;
                  end
                end
              end
            end
            AddrBrdcast: begin
              brdcast_d = frame_data;
              for (int n = 0; n < NUM_CH; n++) begin
                buf_d[n] = frame_data & CodeMask;
                if (!sync_q[n]) begin
                  code_d[n]   = frame_data & CodeMask;
                  update_d[n] = 1'b1;
                end
              end
            end
            default: begin
              for (int n = 0; n < NUM_CH; n++) begin
                if (frame_addr == 4'(8 + n)) begin
                  buf_d[n] = frame_data & CodeMask;
                  if (!sync_q[n]) begin
                    code_d[n]   = frame_data & CodeMask;
                    update_d[n] = 1'b1;
                  end
                end
              end
            end
          endcase
        end
      end
      default: state_d = StIdle;
    endcase

    // Soft reset returns every register to its power-on value, like SYS_RST_N.
    if (soft_rst) begin
      state_d     = StIdle;
      bit_cnt_d   = 5'd0;
      shift_in_d  = 24'h000000;
      shift_out_d = 24'h000000;
      buf_d       = '0;
      code_d      = '0;
      update_d    = '0;
      sync_d      = 16'h0000;
      config_d    = 16'h0000;
      gain_d      = GAIN_RST;
      trigger_d   = 16'h0000;
      brdcast_d   = 16'h0000;
`ifdef DACX_FRAME_ERR_EN
      frame_err_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_s3_q   <= 1'b0;
      cs_s1_q     <= 1'b1;
      cs_s2_q     <= 1'b1;
      cs_s3_q     <= 1'b1;
      sdi_s1_q    <= 1'b0;
      sdi_s2_q    <= 1'b0;
      state_q     <= StIdle;
      bit_cnt_q   <= 5'd0;
      shift_in_q  <= 24'h000000;
      shift_out_q <= 24'h000000;
      buf_q       <= '0;
      code_q      <= '0;
      update_q    <= '0;
      sync_q      <= 16'h0000;
      config_q    <= 16'h0000;
      gain_q      <= GAIN_RST;
      trigger_q   <= 16'h0000;
      brdcast_q   <= 16'h0000;
`ifdef DACX_FRAME_ERR_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      sclk_s1_q   <= bus.DAC_SCLK;
      sclk_s2_q   <= sclk_s1_q;
      sclk_s3_q   <= sclk_s2_q;
      cs_s1_q     <= bus.DAC_CS_N;
      cs_s2_q     <= cs_s1_q;
      cs_s3_q     <= cs_s2_q;
      sdi_s1_q    <= bus.DAC_SDI;
      sdi_s2_q    <= sdi_s1_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      buf_q       <= buf_d;
      code_q      <= code_d;
      update_q    <= update_d;
      sync_q      <= sync_d;
      config_q    <= config_d;
      gain_q      <= gain_d;
      trigger_q   <= trigger_d;
      brdcast_q   <= brdcast_d;
`ifdef DACX_FRAME_ERR_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_dacx_spi_slave_model.sv
// Directed bench for dacx_spi_slave_model: a table of SPI frames with expected readback,
// FRAME_DONE, DAC_UPDATE and DAC_CODE, plus latency and mid-frame reset sequences.
module tb_dacx_spi_slave_model;
  localparam int unsigned NumCh   = 4;
  localparam int unsigned DacBits = 12;

  typedef struct {
    int          nbits;
    logic [31:0] tx;
    bit          chk_rx;
    logic [23:0] exp_rx;
    int          exp_done;
    logic [3:0]  exp_upd;
    logic [63:0] exp_code;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  logic [NumCh-1:0][7:0] upd_cnt = '0;
  logic [NumCh-1:0]      last_upd = '0;
  vec_t tbl[$];

  dacx_spi_slave_model_if #(.NUM_CH(NumCh)) bus ();

  dacx_spi_slave_model #(
    .NUM_CH   (NumCh),
    .DAC_BITS (DacBits),
    .DEVICE_ID(16'hABCD),
    .GAIN_RST (16'h0001)
  ) dut (
    .SYS_CLK  (clk),
    .SYS_RST_N(rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.FRAME_DONE) done_cnt <= done_cnt + 1;
    if (bus.DAC_UPDATE != '0) begin
      last_upd <= bus.DAC_UPDATE;
      for (int n = 0; n < NumCh; n++) begin
        if (bus.DAC_UPDATE[n]) upd_cnt[n] <= upd_cnt[n] + 8'd1;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(int nbits, logic [31:0] tx, bit chk_rx, logic [23:0] exp_rx,
                              int exp_done, logic [3:0] exp_upd, logic [63:0] exp_code);
    vec_t v;
    v.nbits = nbits; v.tx = tx; v.chk_rx = chk_rx; v.exp_rx = exp_rx;
    v.exp_done = exp_done; v.exp_upd = exp_upd; v.exp_code = exp_code;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // SCLK is SYS_CLK/8; SDO is sampled just before each rising SCLK edge.
  task automatic spi_bits(input int nbits, input logic [31:0] tx, output logic [31:0] rx);
    rx = '0;
    bus.DAC_CS_N = 1'b0;
    tick(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.DAC_SDI  = tx[i];
      rx           = {rx[30:0], bus.DAC_SDO};
      bus.DAC_SCLK = 1'b1;
      tick(4);
      bus.DAC_SCLK = 1'b0;
      tick(4);
    end
  endtask

  task automatic spi_frame(input int nbits, input logic [31:0] tx, output logic [31:0] rx);
    spi_bits(nbits, tx, rx);
    bus.DAC_CS_N = 1'b1;
    tick(8);
  endtask

  initial begin
    logic [31:0] rx;
    int d0;
    int lat;
    logic [NumCh-1:0][7:0] u0;
    logic [15:0] gotd, expd;
    logic [23:0] status_rx;

`ifdef DACX_FRAME_ERR_EN
    status_rx = 24'h870002;
`else
    status_rx = 24'h870000;
`endif

    rst_n = 1'b0;
    bus.DAC_CS_N = 1'b1;
    bus.DAC_SCLK = 1'b0;
    bus.DAC_SDI  = 1'b0;
    tick(3);
    check("rst_code", 64'(bus.DAC_CODE), 64'h0);
    check("rst_update", 64'(bus.DAC_UPDATE), 64'h0);
    check("rst_frame_done", 64'(bus.FRAME_DONE), 64'h0);
    check("rst_sdo", 64'(bus.DAC_SDO), 64'h0);
    rst_n = 1'b1;
    tick(3);

    tbl.push_back(mk(24, 32'h810000, 1, 24'h000000, 1, 4'b0000, 64'h0));
    tbl.push_back(mk(24, 32'h000000, 1, 24'h81ABCD, 1, 4'b0000, 64'h0));
    tbl.push_back(mk(24, 32'h020000, 1, 24'h000000, 1, 4'b0000, 64'h0));
    tbl.push_back(mk(24, 32'h0A1234, 0, 24'h0, 1, 4'b0100, 64'h0000_1230_0000_0000));
    tbl.push_back(mk(24, 32'h8A0000, 0, 24'h0, 1, 4'b0000, 64'h0000_1230_0000_0000));
    tbl.push_back(mk(24, 32'h000000, 1, 24'h8A1230, 1, 4'b0000, 64'h0000_1230_0000_0000));
    tbl.push_back(mk(24, 32'h020003, 0, 24'h0, 1, 4'b0000, 64'h0000_1230_0000_0000));
    tbl.push_back(mk(24, 32'h08AAAA, 0, 24'h0, 1, 4'b0000, 64'h0000_1230_0000_0000));
    tbl.push_back(mk(24, 32'h095555, 0, 24'h0, 1, 4'b0000, 64'h0000_1230_0000_0000));
    tbl.push_back(mk(24, 32'h050010, 0, 24'h0, 1, 4'b0011, 64'h0000_1230_5550_AAA0));
    tbl.push_back(mk(24, 32'h020001, 0, 24'h0, 1, 4'b0000, 64'h0000_1230_5550_AAA0));
    tbl.push_back(mk(24, 32'h06FFFF, 0, 24'h0, 1, 4'b1110, 64'hFFF0_FFF0_FFF0_AAA0));
    tbl.push_back(mk(24, 32'h880000, 0, 24'h0, 1, 4'b0000, 64'hFFF0_FFF0_FFF0_AAA0));
    tbl.push_back(mk(24, 32'h000000, 1, 24'h88FFF0, 1, 4'b0000, 64'hFFF0_FFF0_FFF0_AAA0));
    tbl.push_back(mk(24, 32'h050010, 0, 24'h0, 1, 4'b0001, 64'hFFF0_FFF0_FFF0_FFF0));
    tbl.push_back(mk(23, 32'h058000, 0, 24'h0, 0, 4'b0000, 64'hFFF0_FFF0_FFF0_FFF0));
    tbl.push_back(mk(25, 32'h160000, 0, 24'h0, 0, 4'b0000, 64'hFFF0_FFF0_FFF0_FFF0));
    tbl.push_back(mk(24, 32'h870000, 1, 24'h000000, 1, 4'b0000, 64'hFFF0_FFF0_FFF0_FFF0));
    tbl.push_back(mk(24, 32'h870000, 1, status_rx, 1, 4'b0000, 64'hFFF0_FFF0_FFF0_FFF0));
    tbl.push_back(mk(24, 32'h000000, 1, 24'h870000, 1, 4'b0000, 64'hFFF0_FFF0_FFF0_FFF0));
    tbl.push_back(mk(24, 32'h8C0000, 0, 24'h0, 1, 4'b0000, 64'hFFF0_FFF0_FFF0_FFF0));
    tbl.push_back(mk(24, 32'h000000, 1, 24'h8C0000, 1, 4'b0000, 64'hFFF0_FFF0_FFF0_FFF0));
    tbl.push_back(mk(24, 32'h0D1111, 0, 24'h0, 1, 4'b0000, 64'hFFF0_FFF0_FFF0_FFF0));
    tbl.push_back(mk(24, 32'h840000, 0, 24'h0, 1, 4'b0000, 64'hFFF0_FFF0_FFF0_FFF0));
    tbl.push_back(mk(24, 32'h000000, 1, 24'h840001, 1, 4'b0000, 64'hFFF0_FFF0_FFF0_FFF0));
    tbl.push_back(mk(24, 32'h05000A, 0, 24'h0, 1, 4'b0000, 64'h0));
    tbl.push_back(mk(24, 32'h820000, 0, 24'h0, 1, 4'b0000, 64'h0));
    tbl.push_back(mk(24, 32'h000000, 1, 24'h820000, 1, 4'b0000, 64'h0));

    foreach (tbl[k]) begin
      d0 = done_cnt;
      u0 = upd_cnt;
      spi_frame(tbl[k].nbits, tbl[k].tx, rx);
      check($sformatf("v%0d_frame_done", k), 64'(done_cnt - d0), 64'(tbl[k].exp_done));
      check($sformatf("v%0d_code", k), 64'(bus.DAC_CODE), tbl[k].exp_code);
      for (int n = 0; n < NumCh; n++) begin
        gotd[4*n +: 4] = 4'(upd_cnt[n] - u0[n]);
        expd[4*n +: 4] = {3'b000, tbl[k].exp_upd[n]};
      end
      check($sformatf("v%0d_update_cnt", k), 64'(gotd), 64'(expd));
      if (tbl[k].exp_upd != 4'b0000)
        check($sformatf("v%0d_update_same_cycle", k), 64'(last_upd), 64'(tbl[k].exp_upd));
      if (tbl[k].chk_rx)
        check($sformatf("v%0d_sdo", k), 64'(rx[23:0]), 64'(tbl[k].exp_rx));
    end

    // CS_N pin rise to DAC_CODE valid
    spi_bits(24, 32'h0B4321, rx);
    bus.DAC_CS_N = 1'b1;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      tick(1);
      if (lat == 0 && bus.DAC_CODE[63:48] == 16'h4320) lat = c;
    end
    check("latency", 64'(lat), 64'd4);
    tick(8);

    // Async reset in the middle of a DAC0 write
    d0 = done_cnt;
    spi_bits(12, 32'h000081, rx);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    spi_bits(12, 32'h000111, rx);
    bus.DAC_CS_N = 1'b1;
    tick(8);
    check("midrst_code", 64'(bus.DAC_CODE), 64'h0);
    check("midrst_frame_done", 64'(done_cnt - d0), 64'd0);
    spi_frame(24, 32'h084321, rx);
    check("post_rst_code", 64'(bus.DAC_CODE), 64'h0000_0000_0000_4320);
    check("post_rst_frame_done", 64'(done_cnt - d0), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
